mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_if.sv | 24 ++
 rtl/mdu.sv | 162 ++++++++++++++++
 tb/tb_mdu.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Bus between the pipeline and the multiply/divide unit: operation request,
// HI/LO moves, and the status/result signals coming back.
interface mdu_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers.
// One shift-add or restoring-divide step per cycle on operand magnitudes;
// signs are stripped when the operation starts and restored on the final step.
// Result lands in HI/LO 32 edges after the start edge.
module mdu (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic        is_div_q;
    logic        neg_res_q;   // product / quotient must be negated at the end
    logic        neg_rem_q;   // remainder takes the dividend's sign
    logic        div_zero_q;
    logic [31:0] a_q;         // original dividend, returned in HI on divide by zero
    logic [31:0] m_q;         // multiplicand or divisor magnitude
    logic [31:0] acc_hi_q;    // partial product high half, or partial remainder
    logic [31:0] acc_lo_q;    // multiplier shifting out, or dividend -> quotient
    logic [31:0] hi_q, lo_q;
    logic        busy_q, done_q;
    logic        accept, finish;

    logic        signed_op, neg_a, neg_b;
    logic [31:0] mag_a, mag_b;

    logic [32:0] mul_sum, div_shift;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [31:0] acc_hi_d, acc_lo_d;

    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix, hi_res, lo_res;

    // Operand magnitudes for the signed ops (MULT, DIV have op[0] = 0).
    assign signed_op = ~bus.op[0];
    assign neg_a     = signed_op & bus.a[31];
    assign neg_b     = signed_op & bus.b[31];
    assign mag_a     = neg_a ? -bus.a : bus.a;
    assign mag_b     = neg_b ? -bus.b : bus.b;

    // Next-state decode: accept a start in IDLE, leave RUN after the 32nd step.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == 5'd31) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One iteration: shift-add multiply or restoring divide on the accumulator pair.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : 33'd0);
        div_shift = {acc_hi_q, acc_lo_q[31]};
        div_ge    = (div_shift >= {1'b0, m_q});
        // When the subtract is taken the remainder is below the divisor, so 32 bits suffice.
        div_rem   = div_shift[31:0] - m_q;
        if (is_div_q) begin
            acc_hi_d = div_ge ? div_rem : div_shift[31:0];
            acc_lo_d = {acc_lo_q[30:0], div_ge};
        end else begin
            acc_hi_d = mul_sum[32:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
        end
    end

    // Final HI/LO values after sign correction and the divide-by-zero override.
    always_comb begin
        prod     = {acc_hi_d, acc_lo_d};
        prod_fix = neg_res_q ? -prod : prod;
        quo_fix  = neg_res_q ? -acc_lo_d : acc_lo_d;
        rem_fix  = neg_rem_q ? -acc_hi_d : acc_hi_d;
        if (!is_div_q) begin
            {hi_res, lo_res} = prod_fix;
        end else if (div_zero_q) begin
            hi_res = a_q;
            lo_res = 32'hFFFF_FFFF;
        end else begin
            hi_res = rem_fix;
            lo_res = quo_fix;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath, HI/LO and status registers; start beats moves, RUN ignores both.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 5'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_q        <= 32'd0;
            m_q        <= 32'd0;
            acc_hi_q   <= 32'd0;
            acc_lo_q   <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q     <= 1'b1;
                cnt_q      <= 5'd0;
                is_div_q   <= bus.op[1];
                a_q        <= bus.a;
                neg_res_q  <= neg_a ^ neg_b;
                neg_rem_q  <= neg_a;
                div_zero_q <= (bus.b == 32'd0);
                acc_hi_q   <= 32'd0;
                if (bus.op[1]) begin
                    m_q      <= mag_b;
                    acc_lo_q <= mag_a;
                end else begin
                    m_q      <= mag_a;
                    acc_lo_q <= mag_b;
                end
            end else if (state_q == IDLE) begin
                if (bus.mthi) hi_q <= bus.a;
                if (bus.mtlo) lo_q <= bus.a;
            end else begin
                acc_hi_q <= acc_hi_d;
                acc_lo_q <= acc_lo_d;
                cnt_q    <= cnt_q + 5'd1;
                if (finish) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    hi_q   <= hi_res;
                    lo_q   <= lo_res;
                end
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mdu;
    logic clk = 1'b0;
    logic rst;
    mdu_if bus();

    mdu dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // Reference: {HI, LO} from the arithmetic definition of each op.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: p = sa * sb;
            2'b01: p = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        return p;
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
    endtask

    // Issue one op, disturb inputs during RUN, check hold and the result at T+32.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input bit with_move);
        logic [63:0] exp;
        exp = ref_result(op, a, b);
        bus.op = op; bus.a = a; bus.b = b;
        bus.start = 1'b1; bus.mthi = with_move; bus.mtlo = with_move;
        cyc;
        quiet_inputs();
        bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
        tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failed++;
            $display("FAIL start_accept op=%0d: got busy=%b done=%b, expected busy=1 done=0", op, bus.busy, bus.done);
        end
        for (int i = 1; i < 32; i++) begin
            if (i == inject_at) begin
                bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.a = $urandom;
            end
            cyc;
            quiet_inputs();
            tests++;
            if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b10, m_hi, m_lo}) begin
                failed++;
                $display("FAIL run_hold op=%0d cycle=%0d: got busy=%b done=%b hi=%h lo=%h, expected busy=1 done=0 hi=%h lo=%h",
                         op, i, bus.busy, bus.done, bus.hi, bus.lo, m_hi, m_lo);
            end
        end
        cyc;
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        tests++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b01, m_hi, m_lo}) begin
            failed++;
            $display("FAIL result op=%0d a=%h b=%h: got busy=%b done=%b hi=%h lo=%h, expected busy=0 done=1 hi=%h lo=%h",
                     op, a, b, bus.busy, bus.done, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    // One idle cycle after done: pulse must have dropped, HI/LO stable.
    task automatic check_idle(input string name);
        cyc;
        tests++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, m_hi, m_lo}) begin
            failed++;
            $display("FAIL %s: got busy=%b done=%b hi=%h lo=%h, expected busy=0 done=0 hi=%h lo=%h",
                     name, bus.busy, bus.done, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
        bus.op = 2'b00; bus.a = 32'h1234_5678; bus.b = 32'd9;
        cyc;
        cyc;
        tests++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            failed++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, expected all zero", bus.busy, bus.done, bus.hi, bus.lo);
        end
        rst = 1'b0;
        quiet_inputs();
        m_hi = 32'd0; m_lo = 32'd0;
        check_idle("reset_release");
    endtask

    task automatic test_moves;
        logic [31:0] v;
        v = $urandom; bus.a = v; bus.mthi = 1'b1;
        cyc; quiet_inputs(); m_hi = v;
        tests++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
            failed++; $display("FAIL mthi: got hi=%h lo=%h, expected hi=%h lo=%h", bus.hi, bus.lo, m_hi, m_lo);
        end
        v = $urandom; bus.a = v; bus.mtlo = 1'b1;
        cyc; quiet_inputs(); m_lo = v;
        tests++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
            failed++; $display("FAIL mtlo: got hi=%h lo=%h, expected hi=%h lo=%h", bus.hi, bus.lo, m_hi, m_lo);
        end
        v = $urandom; bus.a = v; bus.mthi = 1'b1; bus.mtlo = 1'b1;
        cyc; quiet_inputs(); m_hi = v; m_lo = v;
        tests++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
            failed++; $display("FAIL mthi_mtlo: got hi=%h lo=%h, expected hi=%h lo=%h", bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_directed;
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, -1, 1'b0);
        tests++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            failed++; $display("FAIL mult_neg: got %h_%h, expected FFFFFFFF_FFFFFFFA", bus.hi, bus.lo);
        end
        check_idle("done_pulse_mult");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        tests++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin
            failed++; $display("FAIL multu_max: got %h_%h, expected FFFFFFFE_00000001", bus.hi, bus.lo);
        end
        check_idle("done_pulse_multu");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        tests++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            failed++; $display("FAIL div_neg: got %h_%h, expected FFFFFFFF_FFFFFFFD", bus.hi, bus.lo);
        end
        check_idle("done_pulse_div");
        run_op(2'b11, 32'd7, 32'd0, -1, 1'b0);
        tests++;
        if ({bus.hi, bus.lo} !== 64'h0000_0007_FFFF_FFFF) begin
            failed++; $display("FAIL divu_zero: got %h_%h, expected 00000007_FFFFFFFF", bus.hi, bus.lo);
        end
        check_idle("done_pulse_divu");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, -1, 1'b0);
        tests++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFB_FFFF_FFFF) begin
            failed++; $display("FAIL div_zero: got %h_%h, expected FFFFFFFB_FFFFFFFF", bus.hi, bus.lo);
        end
        check_idle("done_pulse_divz");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        tests++;
        if ({bus.hi, bus.lo} !== 64'h0000_0000_8000_0000) begin
            failed++; $display("FAIL div_overflow: got %h_%h, expected 00000000_80000000", bus.hi, bus.lo);
        end
        check_idle("done_pulse_ovf");
    endtask

    // Start/moves issued mid-operation must be ignored; start with moves in IDLE wins.
    task automatic test_ignore;
        run_op(2'b11, 32'd100, 32'd7, 10, 1'b0);
        tests++;
        if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin
            failed++; $display("FAIL divu_ignore: got hi=%h lo=%h, expected hi=2 lo=14", bus.hi, bus.lo);
        end
        check_idle("done_pulse_ignore");
        run_op(2'b01, $urandom, $urandom, -1, 1'b1);
        check_idle("start_beats_move");
    endtask

    task automatic test_rst_during_run;
        bus.op = 2'b00; bus.a = $urandom; bus.b = $urandom; bus.start = 1'b1;
        cyc;
        quiet_inputs();
        repeat (14) cyc;
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        tests++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            failed++;
            $display("FAIL rst_abort: got busy=%b done=%b hi=%h lo=%h, expected all zero", bus.busy, bus.done, bus.hi, bus.lo);
        end
        for (int i = 0; i < 24; i++) check_idle("rst_no_done");
        bus.a = 32'd5; bus.mtlo = 1'b1;
        cyc;
        quiet_inputs();
        m_lo = 32'd5;
        tests++;
        if (bus.lo !== 32'd5 || bus.hi !== 32'd0) begin
            failed++; $display("FAIL mtlo_after_rst: got hi=%h lo=%h, expected hi=0 lo=5", bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) run_op(2'($urandom), $urandom, $urandom, -1, 1'b0);
        check_idle("back_to_back_end");
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [1:0]  op;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 200);
                default: ;
            endcase
            run_op(op, a, b, $urandom_range(1, 40), 1'($urandom));
            check_idle("random_idle");
        end
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
        test_reset();
        test_moves();
        test_directed();
        test_ignore();
        test_rst_during_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
